dmem_arb: RTL and testbench

Two-requester arbiter and sequencer for the single-port 1024x32 data memory (`datamem`): it shares the memory between the pipeline MEM stage (CPU port) and a burst DMA/loader port. The CPU port owns the memory by default with zero added latency; DMA gets fixed-length, non-preemptible bursts with an auto-incrementing address. `cpu_stall` feeds the pipeline hazard unit.

---
 rtl/dmem_arb_if.sv | 33 +++
 rtl/dmem_arb.sv | 60 ++++++
 tb/tb_dmem_arb.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/dmem_arb_if.sv
// dmem_arb_if: CPU, DMA and datamem signals shared by dmem_arb and its environment.
interface dmem_arb_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;
  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [3:0]        dma_len;
  logic [DATA_W-1:0] dma_wdata;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_ack;
  logic              dma_done;
  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, dma_req, dma_we, dma_addr, dma_len, dma_wdata, mem_dout,
    output cpu_rdata, cpu_stall, dma_rdata, dma_ack, dma_done, mem_we, mem_re, mem_addr, mem_din
  );
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, dma_req, dma_we, dma_addr, dma_len, dma_wdata, mem_dout,
    input  cpu_rdata, cpu_stall, dma_rdata, dma_ack, dma_done, mem_we, mem_re, mem_addr, mem_din
  );
endinterface

// File: rtl/dmem_arb.sv
// dmem_arb: CPU-priority arbiter with non-preemptible DMA bursts for the single-port datamem.
// Define DMEM_ARB_STARVE_EN to force a DMA grant after STARVE_LIM blocked cycles.
module dmem_arb #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int STARVE_LIM = 8
) (
  input  logic          sys_clk,
  input  logic          rst,
  dmem_arb_if.slave     bus
);
  typedef enum logic {S_CPU, S_DMA} state_t;
  state_t            st;
  logic [ADDR_W-1:0] beat_addr;
  logic [3:0]        beat_cnt;
  logic              beat_we;
  logic              dma;
  logic              grant;
  if (STARVE_LIM < 1 || STARVE_LIM > 15) begin : g_lim_chk
    $error("dmem_arb: STARVE_LIM must fit the 4-bit starve counter (1..15)");
  end
`ifdef DMEM_ARB_STARVE_EN
  logic [3:0] starve;
  assign grant = bus.dma_req & (~bus.cpu_req | starve == 4'(STARVE_LIM));
  always_ff @(posedge sys_clk or posedge rst)
    if (rst) starve <= '0;
    else if (!bus.dma_req || grant) starve <= '0;
    else if (!dma && bus.cpu_req) starve <= starve + 4'd1;
`else
  assign grant = bus.dma_req & ~bus.cpu_req;
`endif
  assign dma           = st == S_DMA;
  assign bus.mem_we    = ~rst & (dma ? beat_we : bus.cpu_req & bus.cpu_we);
  assign bus.mem_re    = ~rst & (dma ? ~beat_we : bus.cpu_req & ~bus.cpu_we);
  assign bus.mem_addr  = dma ? beat_addr : bus.cpu_addr;
  assign bus.mem_din   = dma ? bus.dma_wdata : bus.cpu_wdata;
  assign bus.cpu_rdata = bus.mem_dout;
  assign bus.dma_rdata = bus.mem_dout;
  assign bus.cpu_stall = dma & bus.cpu_req;
  assign bus.dma_ack   = dma;
  assign bus.dma_done  = dma & beat_cnt == 4'd0;
  always_ff @(posedge sys_clk or posedge rst)
    if (rst) begin
      st        <= S_CPU;
      beat_addr <= '0;
      beat_cnt  <= '0;
      beat_we   <= 1'b0;
    end else if (!dma) begin
      if (grant) begin
        st        <= S_DMA;
        beat_addr <= bus.dma_addr;
        beat_cnt  <= bus.dma_len;
        beat_we   <= bus.dma_we;
      end
    end else begin
      beat_addr <= beat_addr + 1'b1;
      beat_cnt  <= beat_cnt - 4'd1;
      if (beat_cnt == 4'd0) st <= S_CPU;
    end
endmodule

// File: tb/tb_dmem_arb.sv
// tb_dmem_arb: directed checks of dmem_arb against a behavioural datamem.
// Define DMEM_ARB_STARVE_EN for both bench and RTL to check the starvation timer.
module tb_dmem_arb;
  localparam int STARVE_LIM = 8;
  logic sys_clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] mem [1024];
  dmem_arb_if #(.ADDR_W(10), .DATA_W(32)) bus ();
  dmem_arb #(.ADDR_W(10), .DATA_W(32), .STARVE_LIM(STARVE_LIM)) dut (
    .sys_clk(sys_clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 sys_clk = ~sys_clk;
  assign bus.mem_dout = mem[bus.mem_addr];
  always @(posedge sys_clk) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_din;

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dma_req = 0; bus.dma_we = 0; bus.dma_addr = '0; bus.dma_len = '0; bus.dma_wdata = '0;
  endtask

  task automatic test_reset;
    idle();
    rst = 1;
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 10'h010; bus.cpu_wdata = 32'h1;
    tick(); tick();
    #1;
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", bus.mem_we); end
    checks++; if (bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", bus.cpu_stall); end
    checks++; if (bus.dma_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", bus.dma_ack); end
    idle();
    tick();
    rst = 0;
  endtask

  task automatic test_passthrough;
    tick();
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 10'h105; bus.cpu_wdata = 32'hDEADBEEF;
    #1;
    checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 10'h105 || bus.mem_din !== 32'hDEADBEEF)
      begin errors++; $display("FAIL pt_write: got we=%b addr=%h din=%h want 1 105 deadbeef", bus.mem_we, bus.mem_addr, bus.mem_din); end
    checks++; if (bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL pt_write_stall: got %b want 0", bus.cpu_stall); end
    tick();
    bus.cpu_we = 0;
    #1;
    checks++; if (bus.cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL pt_read: got %h want deadbeef", bus.cpu_rdata); end
    checks++; if (bus.mem_re !== 1'b1 || bus.mem_we !== 1'b0 || bus.cpu_stall !== 1'b0)
      begin errors++; $display("FAIL pt_read_ctl: got re=%b we=%b stall=%b want 1 0 0", bus.mem_re, bus.mem_we, bus.cpu_stall); end
    tick();
    idle();
  endtask

  task automatic test_write_burst;
    logic [9:0] wexp [4];
    wexp = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    tick();
    bus.dma_req = 1; bus.dma_we = 1; bus.dma_len = 4'd3; bus.dma_addr = 10'h3FE;
    #1;
    checks++; if (bus.dma_ack !== 1'b0) begin errors++; $display("FAIL wb_grant_cycle_ack: got %b want 0", bus.dma_ack); end
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.dma_req = 0; bus.dma_len = 4'd9; bus.dma_addr = 10'h123;
      bus.dma_wdata = 32'hA000_0000 + 32'(i);
      #1;
      checks++; if (bus.dma_ack !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== wexp[i])
        begin errors++; $display("FAIL wb_beat%0d: got ack=%b we=%b addr=%h want 1 1 %h", i, bus.dma_ack, bus.mem_we, bus.mem_addr, wexp[i]); end
      checks++; if (bus.dma_done !== (i == 3))
        begin errors++; $display("FAIL wb_done%0d: got %b want %b", i, bus.dma_done, i == 3); end
    end
    tick();
    #1;
    checks++; if (bus.dma_ack !== 1'b0) begin errors++; $display("FAIL wb_end_ack: got %b want 0", bus.dma_ack); end
    for (int i = 0; i < 4; i++) begin
      bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = wexp[i];
      #1;
      checks++; if (bus.cpu_rdata !== 32'hA000_0000 + 32'(i))
        begin errors++; $display("FAIL wb_readback%0d: got %h want %h", i, bus.cpu_rdata, 32'hA000_0000 + 32'(i)); end
      tick();
    end
    idle();
  endtask

  task automatic test_cpu_held_off;
    int stalls;
    for (int i = 0; i < 16; i++) begin
      bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 10'h200 + 10'(i); bus.cpu_wdata = 32'h5500_0000 + 32'(i);
      tick();
    end
    idle();
    tick();
    bus.dma_req = 1; bus.dma_we = 0; bus.dma_len = 4'd15; bus.dma_addr = 10'h200;
    tick();
    bus.dma_req = 0;
    #1;
    checks++; if (bus.dma_ack !== 1'b1 || bus.dma_rdata !== 32'h5500_0000 || bus.cpu_stall !== 1'b0)
      begin errors++; $display("FAIL ho_beat0: got ack=%b rdata=%h stall=%b want 1 55000000 0", bus.dma_ack, bus.dma_rdata, bus.cpu_stall); end
    stalls = 0;
    for (int i = 1; i < 16; i++) begin
      tick();
      bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 10'h105;
      #1;
      if (bus.cpu_stall === 1'b1) stalls++;
      checks++; if (bus.dma_rdata !== 32'h5500_0000 + 32'(i) || bus.mem_re !== 1'b1 || bus.mem_we !== 1'b0)
        begin errors++; $display("FAIL ho_beat%0d: got rdata=%h re=%b we=%b want %h 1 0", i, bus.dma_rdata, bus.mem_re, bus.mem_we, 32'h5500_0000 + 32'(i)); end
      checks++; if (bus.dma_done !== (i == 15))
        begin errors++; $display("FAIL ho_done%0d: got %b want %b", i, bus.dma_done, i == 15); end
    end
    checks++; if (stalls != 15) begin errors++; $display("FAIL ho_stall_count: got %0d want 15", stalls); end
    tick();
    #1;
    checks++; if (bus.cpu_stall !== 1'b0 || bus.dma_ack !== 1'b0 || bus.cpu_rdata !== 32'hDEADBEEF)
      begin errors++; $display("FAIL ho_cpu_served: got stall=%b ack=%b rdata=%h want 0 0 deadbeef", bus.cpu_stall, bus.dma_ack, bus.cpu_rdata); end
    tick();
    idle();
  endtask

  task automatic test_starvation;
    int first;
    tick();
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 10'h105;
    bus.dma_req = 1; bus.dma_we = 0; bus.dma_len = 4'd0; bus.dma_addr = 10'h050;
    first = -1;
    for (int c = 0; c <= 100; c++) begin
      #1;
      if (bus.dma_ack === 1'b1 && first < 0) first = c;
      tick();
    end
`ifdef DMEM_ARB_STARVE_EN
    checks++; if (first != STARVE_LIM + 1) begin errors++; $display("FAIL starve_first_ack: got %0d want %0d", first, STARVE_LIM + 1); end
`else
    checks++; if (first != -1) begin errors++; $display("FAIL prio_no_ack: got first ack at %0d want none", first); end
`endif
    idle();
    tick(); tick();
  endtask

  task automatic test_reset_mid_burst;
    int bad;
    for (int i = 0; i < 9; i++) begin
      bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 10'h300 + 10'(i); bus.cpu_wdata = 32'h0;
      tick();
    end
    idle();
    tick();
    bus.dma_req = 1; bus.dma_we = 1; bus.dma_len = 4'd7; bus.dma_addr = 10'h300;
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.dma_req = 0;
      bus.dma_wdata = 32'h7700_0000 + 32'(i);
      #1;
      checks++; if (bus.dma_ack !== 1'b1) begin errors++; $display("FAIL rmb_beat%0d_ack: got %b want 1", i, bus.dma_ack); end
    end
    rst = 1;
    #1;
    checks++; if (bus.mem_we !== 1'b0 || bus.dma_ack !== 1'b0 || bus.dma_done !== 1'b0 || bus.cpu_stall !== 1'b0)
      begin errors++; $display("FAIL rmb_in_reset: got we=%b ack=%b done=%b stall=%b want 0 0 0 0", bus.mem_we, bus.dma_ack, bus.dma_done, bus.cpu_stall); end
    tick();
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rmb_reset_we: got %b want 0", bus.mem_we); end
    rst = 0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.dma_ack !== 1'b0 || bus.dma_done !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rmb_no_more_beats: got %0d active cycles want 0", bad); end
    for (int i = 0; i < 9; i++) begin
      checks++; if (mem[10'h300 + 10'(i)] !== (i < 2 ? 32'h7700_0000 + 32'(i) : 32'h0))
        begin errors++; $display("FAIL rmb_mem%0d: got %h want %h", i, mem[10'h300 + 10'(i)], i < 2 ? 32'h7700_0000 + 32'(i) : 32'h0); end
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_write_burst();
    test_cpu_held_off();
    test_starvation();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
